branch_target_unit: RTL and testbench
=====================================

# branch_target_unit

Parametrised, pipelined successor to the datapath branch-target adder. Computes `target = pc_plus4 + (sign-extended offset << SHIFT)` with a registered valid/ready result stage. Selects the next PC from the resolved branch condition. Maintains a small direct-mapped branch target buffer (BTB), updated on resolved branches and queried by the fetch stage. Sits between decode/execute (branch resolution) and the PC-select logic.

## Interface
Parameters:
- `WIDTH`, 32: address/data width.
- `SHIFT`, 2: left shift applied to the offset (word alignment).
- `BTB_DEPTH`, 8: BTB entries; power of two, ≥2. `IDX_W = log2(BTB_DEPTH)`, `TAG_W = WIDTH - SHIFT - IDX_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: branch operands valid.
- `in_ready` out 1: unit can accept.
- `in_pc_plus4` in WIDTH: PC of branch + (1<<SHIFT).
- `in_imm` in WIDTH: sign-extended offset (unshifted).
- `in_taken` in 1: resolved branch condition.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_target` out WIDTH: computed branch target.
- `out_next_pc` out WIDTH: `out_target` if taken, else pc_plus4.
- `out_taken` out 1: registered copy of `in_taken`.
- `lookup_pc` in WIDTH: fetch PC to query in the BTB.
- `lookup_hit` out 1: BTB hit for the previous cycle's `lookup_pc`.
- `lookup_target` out WIDTH: predicted target on hit, 0 on miss.
- `flush` in 1: invalidates the whole BTB and drops any pending result.

## Operation
- Arithmetic:
  - `target = in_pc_plus4 + (in_imm << SHIFT)`, truncated to WIDTH, modulo 2^WIDTH.
  - Bits shifted out of `in_imm` are discarded. No overflow flag.
- Handshake:
  - Accept when `in_valid && in_ready`.
  - `in_ready = (!out_valid || out_ready) && !flush` (combinational).
  - Result register loads on accept.
  - `out_valid` stays high and outputs stay stable until `out_valid && out_ready`.
  - Accept and drain in the same cycle are allowed (full throughput, 1 result/cycle).
- Branch PC: `bpc = in_pc_plus4 - (1<<SHIFT)`.
  - Index = `bpc[SHIFT +: IDX_W]`.
  - Tag = `bpc[WIDTH-1 : SHIFT+IDX_W]`.
- BTB update, on an accepted transaction only:
  - Taken: write {valid=1, tag, target} to the indexed entry, overwriting any previous occupant.
  - Not taken: if the entry is valid and its tag matches, clear its valid bit; otherwise no change.
- BTB lookup: index/tag from `lookup_pc` the same way.
  - Hit = entry valid && tag equal.
  - `lookup_hit`/`lookup_target` are registered.
  - `lookup_target` is forced to 0 on a miss.
- Flush, on the edge where `flush=1`:
  - All BTB valid bits clear.
  - `out_valid` → 0.
  - No accept occurs (`in_ready=0`).
  - `lookup_hit` at the next edge is 0.
- No state machine beyond the one-entry result register; its two states are EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain+accept, or on stall.

## Timing
- Reset (`rst_n=0` at an edge):
  - `out_valid=0`, `out_target=0`, `out_next_pc=0`, `out_taken=0`, `lookup_hit=0`, `lookup_target=0`.
  - All BTB valid bits 0.
  - Reset mid-operation discards the pending result and performs no BTB write that cycle. Reset overrides `flush`.
- Compute latency: accept at edge N → `out_valid=1` with result after edge N.
- BTB write takes effect at the accept edge N.
  - A lookup presented in the cycle before edge N sees pre-write contents (read-before-write).
  - A lookup presented after edge N sees the new entry; its result appears after edge N+1.
- Lookup latency: `lookup_pc` sampled at edge N → result valid after edge N, held until the next edge.
- Backpressure: while FULL and `out_ready=0`, `in_ready=0` and `in_valid` operands must be held by the producer.

## Test plan
- Forward taken: `in_pc_plus4=0x00400004`, `in_imm=0x00000003`, `in_taken=1`, `out_ready=1` → next cycle `out_valid=1`, `out_target=0x00400010`, `out_next_pc=0x00400010`, `out_taken=1`.
- Backward / not taken / wrap:
  - `imm=0xFFFFFFFE`, `pc_plus4=0x00400004`, not taken → `out_target=0x003FFFFC`, `out_next_pc=0x00400004`.
  - `pc_plus4=0xFFFFFFFC`, `imm=2` → `out_target=0x00000004`.
- BTB hit/miss/alias:
  - After the first scenario, lookup `0x00400000` → `lookup_hit=1`, `lookup_target=0x00400010`.
  - Lookup `0x00400020` (same index 0, different tag) → hit=0, target=0.
  - Not-taken resolution at `pc_plus4=0x00400004`, then lookup `0x00400000` → hit=0.
- Same-cycle write/lookup: lookup `0x00400000` in the accept cycle of a taken branch at `bpc 0x00400000` → old (miss). Repeating the lookup next cycle → hit.
- Backpressure: `out_ready=0` with two back-to-back transactions → first held stable, `in_ready=0`. Raising `out_ready` → first drains, second accepted the same cycle, `out_valid` stays 1.
- Flush and reset:
  - Populate entries 0 and 3, assert `flush` with a pending result → `out_valid=0`, subsequent lookups miss, `in_ready=0` during flush.
  - `rst_n=0` with a result pending → all outputs 0 after the edge.

Source files
------------

// File: rtl/branch_target_unit.sv
// Branch target adder with a one-entry valid/ready result register and a small
// direct-mapped branch target buffer queried by fetch.
module branch_target_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SHIFT     = 2,
   parameter int unsigned BTB_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc_plus4,
   input  logic [WIDTH-1:0] in_imm,
   input  logic             in_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_target,
   output logic [WIDTH-1:0] out_next_pc,
   output logic             out_taken,
   input  logic [WIDTH-1:0] lookup_pc,
   output logic             lookup_hit,
   output logic [WIDTH-1:0] lookup_target,
   input  logic             flush
);

   localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
   localparam int unsigned TAG_W = WIDTH - SHIFT - IDX_W;
   localparam logic [WIDTH-1:0] INSN_BYTES = WIDTH'(1) << SHIFT;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_target_q, out_target_d;
   logic [WIDTH-1:0] out_next_pc_q, out_next_pc_d;
   logic             out_taken_q, out_taken_d;
   logic             lookup_hit_q, lookup_hit_d;
   logic [WIDTH-1:0] lookup_target_q, lookup_target_d;

   logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;
   logic [TAG_W-1:0]     btb_tag_q    [BTB_DEPTH];
   logic [TAG_W-1:0]     btb_tag_d    [BTB_DEPTH];
   logic [WIDTH-1:0]     btb_target_q [BTB_DEPTH];
   logic [WIDTH-1:0]     btb_target_d [BTB_DEPTH];

   logic             accept;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] bpc;
   logic [IDX_W-1:0] wr_idx, lk_idx;
   logic [TAG_W-1:0] wr_tag, lk_tag;
   logic             unused_low_bits;

   assign in_ready = (!out_valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign target   = in_pc_plus4 + (in_imm << SHIFT);
   assign bpc      = in_pc_plus4 - INSN_BYTES;

   assign wr_idx = bpc[SHIFT +: IDX_W];
   assign wr_tag = bpc[WIDTH-1 -: TAG_W];
   assign lk_idx = lookup_pc[SHIFT +: IDX_W];
   assign lk_tag = lookup_pc[WIDTH-1 -: TAG_W];

   // Byte-offset bits never take part in indexing or tagging.
   assign unused_low_bits = ^{bpc[SHIFT-1:0], lookup_pc[SHIFT-1:0]};

   always_comb begin
      out_valid_d   = out_valid_q;
      out_target_d  = out_target_q;
      out_next_pc_d = out_next_pc_q;
      out_taken_d   = out_taken_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         out_target_d  = target;
         out_next_pc_d = in_taken ? target : in_pc_plus4;
         out_taken_d   = in_taken;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      btb_valid_d  = btb_valid_q;
      btb_tag_d    = btb_tag_q;
      btb_target_d = btb_target_q;
      if (flush) begin
         btb_valid_d = '0;
      end else if (accept) begin
         if (in_taken) begin
            btb_valid_d[wr_idx]  = 1'b1;
            btb_tag_d[wr_idx]    = wr_tag;
            btb_target_d[wr_idx] = target;
         end else if (btb_valid_q[wr_idx] && (btb_tag_q[wr_idx] == wr_tag)) begin
            btb_valid_d[wr_idx] = 1'b0;
         end
      end
   end

   // Lookup reads the pre-update array, so a same-edge write is not visible.
   always_comb begin
      lookup_hit_d    = !flush && btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
      lookup_target_d = lookup_hit_d ? btb_target_q[lk_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q     <= 1'b0;
         out_target_q    <= '0;
         out_next_pc_q   <= '0;
         out_taken_q     <= 1'b0;
         lookup_hit_q    <= 1'b0;
         lookup_target_q <= '0;
         btb_valid_q     <= '0;
      end else begin
         out_valid_q     <= out_valid_d;
         out_target_q    <= out_target_d;
         out_next_pc_q   <= out_next_pc_d;
         out_taken_q     <= out_taken_d;
         lookup_hit_q    <= lookup_hit_d;
         lookup_target_q <= lookup_target_d;
         btb_valid_q     <= btb_valid_d;
      end
   end

   // Tag and target payloads are qualified by the valid bits and need no reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         btb_tag_q    <= btb_tag_d;
         btb_target_q <= btb_target_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_target    = out_target_q;
   assign out_next_pc   = out_next_pc_q;
   assign out_taken     = out_taken_q;
   assign lookup_hit    = lookup_hit_q;
   assign lookup_target = lookup_target_q;

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit: directed vector table, hand-written
// BTB/handshake sequences, then randomized traffic against a reference model.
module tb_branch_target_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_pc_plus4, in_imm;
   logic        in_taken;
   logic        out_valid, out_ready;
   logic [31:0] out_target, out_next_pc;
   logic        out_taken;
   logic [31:0] lookup_pc;
   logic        lookup_hit;
   logic [31:0] lookup_target;
   logic        flush;

   int n_vec = 0;
   int n_err = 0;

   branch_target_unit #(.WIDTH(32), .SHIFT(2), .BTB_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .in_taken(in_taken),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_target(out_target), .out_next_pc(out_next_pc), .out_taken(out_taken),
      .lookup_pc(lookup_pc), .lookup_hit(lookup_hit), .lookup_target(lookup_target),
      .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      logic        taken;
      logic [31:0] exp_target;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs[5];

   // Reference model state
   logic        m_ov, m_tk, m_hit;
   logic [31:0] m_tgt, m_nxt, m_lt;
   logic        m_bv  [8];
   logic [31:0] m_bpc [8];
   logic [31:0] m_btgt[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic tk);
      in_valid    = v;
      in_pc_plus4 = pc;
      in_imm      = imm;
      in_taken    = tk;
   endtask

   initial begin
      logic        hold, acc, exp_ready;
      logic [31:0] bpc, tgt;
      int          ix, lx;

      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; lookup_pc = '0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick(); tick();
      chk("reset out_valid", {31'b0, out_valid}, 32'h0);
      chk("reset out_target", out_target, 32'h0);
      chk("reset out_next_pc", out_next_pc, 32'h0);
      chk("reset out_taken", {31'b0, out_taken}, 32'h0);
      chk("reset lookup_hit", {31'b0, lookup_hit}, 32'h0);
      chk("reset lookup_target", lookup_target, 32'h0);
      rst_n = 1'b1;

      // Directed arithmetic table
      vecs[0] = '{32'h0040_0004, 32'h0000_0003, 1'b1, 32'h0040_0010, 32'h0040_0010};
      vecs[1] = '{32'h0040_0004, 32'hFFFF_FFFE, 1'b0, 32'h003F_FFFC, 32'h0040_0004};
      vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0002, 1'b1, 32'h0000_0004, 32'h0000_0004};
      vecs[3] = '{32'h0000_1000, 32'h8000_0000, 1'b1, 32'h0000_1000, 32'h0000_1000};
      vecs[4] = '{32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0004};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, vecs[i].pc, vecs[i].imm, vecs[i].taken);
         tick();
         chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'h1);
         chk($sformatf("vec%0d out_target", i), out_target, vecs[i].exp_target);
         chk($sformatf("vec%0d out_next_pc", i), out_next_pc, vecs[i].exp_next);
         chk($sformatf("vec%0d out_taken", i), {31'b0, out_taken}, {31'b0, vecs[i].taken});
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      chk("drain out_valid", {31'b0, out_valid}, 32'h0);

      // Clean BTB
      rst_n = 1'b0; tick(); rst_n = 1'b1;

      // Same-cycle write/lookup sees old contents; next cycle hits
      drive(1'b1, 32'h0040_0004, 32'h0000_0003, 1'b1);
      lookup_pc = 32'h0040_0000;
      tick();
      chk("rbw lookup_hit", {31'b0, lookup_hit}, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      chk("hit lookup_hit", {31'b0, lookup_hit}, 32'h1);
      chk("hit lookup_target", lookup_target, 32'h0040_0010);
      lookup_pc = 32'h0040_0020;
      tick();
      chk("alias lookup_hit", {31'b0, lookup_hit}, 32'h0);
      chk("alias lookup_target", lookup_target, 32'h0);
      lookup_pc = 32'h0000_0000;
      drive(1'b1, 32'h0040_0004, 32'h0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      lookup_pc = 32'h0040_0000;
      tick();
      chk("not-taken invalidate lookup_hit", {31'b0, lookup_hit}, 32'h0);

      // Backpressure
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0100, 32'h1, 1'b1);
      tick();
      chk("bp A out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp A out_target", out_target, 32'h0000_0104);
      drive(1'b1, 32'h0000_0200, 32'h10, 1'b0);
      #1;
      chk("bp stall in_ready", {31'b0, in_ready}, 32'h0);
      tick(); tick();
      chk("bp held out_target", out_target, 32'h0000_0104);
      chk("bp held out_valid", {31'b0, out_valid}, 32'h1);
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", {31'b0, in_ready}, 32'h1);
      tick();
      chk("bp B out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp B out_target", out_target, 32'h0000_0240);
      chk("bp B out_next_pc", out_next_pc, 32'h0000_0200);
      chk("bp B out_taken", {31'b0, out_taken}, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      chk("bp empty out_valid", {31'b0, out_valid}, 32'h0);

      // Flush with populated entries 0 and 3 and a pending result
      drive(1'b1, 32'h0040_0004, 32'h3, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0010, 32'h4, 1'b1);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0300, 32'h0, 1'b1);
      lookup_pc = 32'h0000_000C;
      tick();
      chk("pre-flush lookup_hit", {31'b0, lookup_hit}, 32'h1);
      chk("pre-flush lookup_target", lookup_target, 32'h0000_0020);
      flush = 1'b1; out_ready = 1'b1;
      drive(1'b1, 32'h0000_0400, 32'h0, 1'b1);
      lookup_pc = 32'h0040_0000;
      #1;
      chk("flush in_ready", {31'b0, in_ready}, 32'h0);
      tick();
      chk("flush out_valid", {31'b0, out_valid}, 32'h0);
      chk("flush lookup_hit", {31'b0, lookup_hit}, 32'h0);
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      chk("post-flush idx0 hit", {31'b0, lookup_hit}, 32'h0);
      chk("post-flush no accept", {31'b0, out_valid}, 32'h0);
      lookup_pc = 32'h0000_000C;
      tick();
      chk("post-flush idx3 hit", {31'b0, lookup_hit}, 32'h0);
      chk("post-flush idx3 target", lookup_target, 32'h0);

      // Reset mid-operation: pending result, concurrent taken write and flush
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0500, 32'h2, 1'b1);
      tick();
      lookup_pc = 32'h0000_0500 - 32'h4;
      tick();
      chk("pre-reset hit", {31'b0, lookup_hit}, 32'h1);
      rst_n = 1'b0; flush = 1'b1;
      drive(1'b1, 32'h0040_0004, 32'h3, 1'b1);
      tick();
      chk("mid-reset out_valid", {31'b0, out_valid}, 32'h0);
      chk("mid-reset out_target", out_target, 32'h0);
      chk("mid-reset out_next_pc", out_next_pc, 32'h0);
      chk("mid-reset out_taken", {31'b0, out_taken}, 32'h0);
      chk("mid-reset lookup_hit", {31'b0, lookup_hit}, 32'h0);
      chk("mid-reset lookup_target", lookup_target, 32'h0);
      rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      lookup_pc = 32'h0040_0000;
      tick();
      chk("post-reset no write", {31'b0, lookup_hit}, 32'h0);
      lookup_pc = 32'h0000_04FC;
      tick();
      chk("post-reset cleared", {31'b0, lookup_hit}, 32'h0);

      // Randomized traffic vs. reference model
      m_ov = 1'b0; m_tk = 1'b0; m_hit = 1'b0; m_tgt = '0; m_nxt = '0; m_lt = '0;
      for (int i = 0; i < 8; i++) begin
         m_bv[i] = 1'b0; m_bpc[i] = '0; m_btgt[i] = '0;
      end
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      hold = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            bpc = $urandom_range(0, 2) * 32'h1000 + $urandom_range(0, 7) * 4;
            drive($urandom_range(0, 3) != 0, bpc + 32'h4,
                  ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15),
                  $urandom_range(0, 2) != 0);
         end
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 24) == 0;
         lookup_pc = $urandom_range(0, 2) * 32'h1000 + $urandom_range(0, 7) * 4
                     + $urandom_range(0, 3);
         #1;
         exp_ready = (!m_ov || out_ready) && !flush;
         chk("rand in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
         acc = in_valid && exp_ready;

         lx = int'((lookup_pc >> 2) % 8);
         m_hit = !flush && m_bv[lx] && ((m_bpc[lx] >> 5) == (lookup_pc >> 5));
         m_lt  = m_hit ? m_btgt[lx] : 32'h0;

         bpc = in_pc_plus4 - 32'd4;
         ix  = int'((bpc >> 2) % 8);
         tgt = in_pc_plus4 + in_imm * 32'd4;
         if (flush) begin
            for (int i = 0; i < 8; i++) m_bv[i] = 1'b0;
            m_ov = 1'b0;
         end else if (acc) begin
            if (in_taken) begin
               m_bv[ix] = 1'b1; m_bpc[ix] = bpc; m_btgt[ix] = tgt;
            end else if (m_bv[ix] && ((m_bpc[ix] >> 5) == (bpc >> 5))) begin
               m_bv[ix] = 1'b0;
            end
            m_ov = 1'b1; m_tgt = tgt; m_tk = in_taken;
            m_nxt = in_taken ? tgt : in_pc_plus4;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         hold = in_valid && !acc;

         tick();
         chk("rand out_valid", {31'b0, out_valid}, {31'b0, m_ov});
         if (m_ov) begin
            chk("rand out_target", out_target, m_tgt);
            chk("rand out_next_pc", out_next_pc, m_nxt);
            chk("rand out_taken", {31'b0, out_taken}, {31'b0, m_tk});
         end
         chk("rand lookup_hit", {31'b0, lookup_hit}, {31'b0, m_hit});
         chk("rand lookup_target", lookup_target, m_lt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
